// File: rtl/ingress_pkg.sv
// Shared header-field positions, limits and FSM encoding for the subunit ingress arbiter.
package ingress_pkg;

  localparam int HDR_WIDTH_DEFAULT = 128;
  localparam int HDR_FMT_BIT       = 30;
  localparam int HDR_LEN_LSB       = 0;
  localparam int HDR_LEN_WIDTH     = 10;
  localparam int MAX_PAYLOAD_DW    = 1024;
  localparam int DW_COUNT_WIDTH    = 11;

  typedef enum logic [1:0] {
    ST_IDLE    = 2'd0,
    ST_HDR     = 2'd1,
    ST_PAYLOAD = 2'd2,
    ST_DONE    = 2'd3
  } arb_state_t;

  // A zero length field encodes the maximum payload size.
  function automatic logic [DW_COUNT_WIDTH-1:0] payload_dw_count(
    input logic [HDR_LEN_WIDTH-1:0] len
  );
    if (len == '0) return DW_COUNT_WIDTH'(MAX_PAYLOAD_DW);
    return {1'b0, len};
  endfunction

endpackage

// File: rtl/rr_arbiter.sv
// Combinational round-robin pick: highest priority at ptr, then ascending index with wrap.
module rr_arbiter #(
  parameter int NUM_LINKS = 4,
  parameter int IDX_W     = (NUM_LINKS > 1) ? $clog2(NUM_LINKS) : 1
) (
  input  logic [NUM_LINKS-1:0] req,
  input  logic [IDX_W-1:0]     ptr,
  output logic [NUM_LINKS-1:0] winner_onehot,
  output logic [IDX_W-1:0]     winner_idx,
  output logic                 winner_valid
);

  logic [NUM_LINKS-1:0] req_rot;

  // req_rot[k] is the request that sits k places after the pointer.
  for (genvar gi = 0; gi < NUM_LINKS; gi++) begin : g_rot
    assign req_rot[gi] = req[IDX_W'((int'(ptr) + gi) % NUM_LINKS)];
  end

  always_comb begin
    winner_onehot = '0;
    winner_idx    = '0;
    winner_valid  = 1'b0;
    // Scan from the far end so the closest request to the pointer is the last written.
    for (int k = NUM_LINKS - 1; k >= 0; k--) begin
      if (req_rot[k]) begin
        winner_valid = 1'b1;
        winner_idx   = IDX_W'((int'(ptr) + k) % NUM_LINKS);
      end
    end
    if (winner_valid) winner_onehot[winner_idx] = 1'b1;
  end

endmodule

// File: rtl/subunit_ingress_arbiter.sv
// Arbitrates several ingress link routers onto one subunit input, forwarding
// one header and its payload DWs per grant with buffer-full back-pressure.
module subunit_ingress_arbiter
  import ingress_pkg::*;
#(
  parameter int NUM_LINKS    = 4,
  parameter int DATA_WIDTH   = 32,
  parameter int HEADER_WIDTH = HDR_WIDTH_DEFAULT
) (
  input  logic                               clk,
  input  logic                               rst_n,
  input  logic [NUM_LINKS-1:0]               req_valid,
  input  logic [NUM_LINKS*HEADER_WIDTH-1:0]  req_header,
  input  logic [NUM_LINKS*DATA_WIDTH-1:0]    req_payload,
  input  logic [NUM_LINKS-1:0]               req_payload_valid,
  output logic [NUM_LINKS-1:0]               grant,
  input  logic                               subunit_input_buffer_full,
  output logic [HEADER_WIDTH-1:0]            out_header,
  output logic                               out_header_valid,
  output logic [DATA_WIDTH-1:0]              out_payload,
  output logic                               out_payload_valid,
  output logic                               out_last,
  output logic                               busy
);

  localparam int IDX_W = (NUM_LINKS > 1) ? $clog2(NUM_LINKS) : 1;

  arb_state_t                state_reg, state_next;
  logic [IDX_W-1:0]          winner_reg, winner_next;
  logic [IDX_W-1:0]          rr_ptr_reg, rr_ptr_next;
  logic [NUM_LINKS-1:0]      grant_reg, grant_next;
  logic [DW_COUNT_WIDTH-1:0] dw_count_reg, dw_count_next;
  logic [HEADER_WIDTH-1:0]   out_header_reg, out_header_next;
  logic                      out_header_valid_reg, out_header_valid_next;
  logic [DATA_WIDTH-1:0]     out_payload_reg, out_payload_next;
  logic                      out_payload_valid_reg, out_payload_valid_next;
  logic                      out_last_reg, out_last_next;

  logic [NUM_LINKS-1:0]      arb_onehot;
  logic [IDX_W-1:0]          arb_idx;
  logic                      arb_valid;

  logic [HEADER_WIDTH-1:0]   link_header  [NUM_LINKS];
  logic [DATA_WIDTH-1:0]     link_payload [NUM_LINKS];
  logic [HEADER_WIDTH-1:0]   win_header;
  logic [DATA_WIDTH-1:0]     win_payload;
  logic                      win_req_valid;
  logic                      win_payload_valid;

  for (genvar gi = 0; gi < NUM_LINKS; gi++) begin : g_unpack
    assign link_header[gi]  = req_header[gi*HEADER_WIDTH +: HEADER_WIDTH];
    assign link_payload[gi] = req_payload[gi*DATA_WIDTH +: DATA_WIDTH];
  end

  assign win_header        = link_header[winner_reg];
  assign win_payload       = link_payload[winner_reg];
  assign win_req_valid     = req_valid[winner_reg];
  assign win_payload_valid = req_payload_valid[winner_reg];

  rr_arbiter #(
    .NUM_LINKS (NUM_LINKS),
    .IDX_W     (IDX_W)
  ) u_rr_arbiter (
    .req           (req_valid),
    .ptr           (rr_ptr_reg),
    .winner_onehot (arb_onehot),
    .winner_idx    (arb_idx),
    .winner_valid  (arb_valid)
  );

  always_comb begin
    state_next             = state_reg;
    winner_next            = winner_reg;
    rr_ptr_next            = rr_ptr_reg;
    grant_next             = grant_reg;
    dw_count_next          = dw_count_reg;
    out_header_next        = out_header_reg;
    out_header_valid_next  = 1'b0;
    out_payload_next       = out_payload_reg;
    out_payload_valid_next = 1'b0;
    out_last_next          = 1'b0;

    case (state_reg)
      ST_IDLE: begin
        if (arb_valid) begin
          winner_next = arb_idx;
          grant_next  = arb_onehot;
          state_next  = ST_HDR;
        end
      end

      ST_HDR: begin
        // A withdrawn request drops the grant without advancing the pointer.
        if (!win_req_valid) begin
          grant_next = '0;
          state_next = ST_IDLE;
        end else if (!subunit_input_buffer_full) begin
          out_header_next       = win_header;
          out_header_valid_next = 1'b1;
          if (win_header[HDR_FMT_BIT]) begin
            dw_count_next = payload_dw_count(win_header[HDR_LEN_LSB +: HDR_LEN_WIDTH]);
            state_next    = ST_PAYLOAD;
          end else begin
            grant_next = '0;
            state_next = ST_DONE;
          end
        end
      end

      ST_PAYLOAD: begin
        if (win_payload_valid && !subunit_input_buffer_full) begin
          out_payload_next       = win_payload;
          out_payload_valid_next = 1'b1;
          dw_count_next          = dw_count_reg - DW_COUNT_WIDTH'(1);
          if (dw_count_reg == DW_COUNT_WIDTH'(1)) begin
            out_last_next = 1'b1;
            grant_next    = '0;
            state_next    = ST_DONE;
          end
        end
      end

      ST_DONE: begin
        rr_ptr_next = (int'(winner_reg) == NUM_LINKS - 1) ? '0 : winner_reg + IDX_W'(1);
        state_next  = ST_IDLE;
      end

      default: state_next = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_reg             <= ST_IDLE;
      winner_reg            <= '0;
      rr_ptr_reg            <= '0;
      grant_reg             <= '0;
      dw_count_reg          <= '0;
      out_header_reg        <= '0;
      out_header_valid_reg  <= 1'b0;
      out_payload_reg       <= '0;
      out_payload_valid_reg <= 1'b0;
      out_last_reg          <= 1'b0;
    end else begin
      state_reg             <= state_next;
      winner_reg            <= winner_next;
      rr_ptr_reg            <= rr_ptr_next;
      grant_reg             <= grant_next;
      dw_count_reg          <= dw_count_next;
      out_header_reg        <= out_header_next;
      out_header_valid_reg  <= out_header_valid_next;
      out_payload_reg       <= out_payload_next;
      out_payload_valid_reg <= out_payload_valid_next;
      out_last_reg          <= out_last_next;
    end
  end

  assign grant             = grant_reg;
  assign out_header        = out_header_reg;
  assign out_header_valid  = out_header_valid_reg;
  assign out_payload       = out_payload_reg;
  assign out_payload_valid = out_payload_valid_reg;
  assign out_last          = out_last_reg;
  assign busy              = (state_reg != ST_IDLE);

endmodule

// File: tb/tb_subunit_ingress_arbiter.sv
// Self-checking bench: a thread-style packet model predicts every output each cycle,
// plus directed scenarios with hand-computed expectations.
module tb_subunit_ingress_arbiter;

  localparam int N  = 4;
  localparam int DW = 32;
  localparam int HW = 128;

  logic            clk = 1'b0;
  logic            rst_n = 1'b0;
  logic [N-1:0]    req_valid = '0;
  logic [N*HW-1:0] req_header = '0;
  logic [N*DW-1:0] req_payload = '0;
  logic [N-1:0]    req_payload_valid = '0;
  logic            full = 1'b0;
  logic [N-1:0]    grant;
  logic [HW-1:0]   out_header;
  logic            out_header_valid;
  logic [DW-1:0]   out_payload;
  logic            out_payload_valid;
  logic            out_last;
  logic            busy;

  int n_checks = 0;
  int n_pass   = 0;

  // Model expectations
  logic [N-1:0]  e_grant = '0;
  logic [HW-1:0] e_hdr   = '0;
  logic          e_hdr_v = 1'b0;
  logic [DW-1:0] e_pay   = '0;
  logic          e_pay_v = 1'b0;
  logic          e_last  = 1'b0;
  logic          e_busy  = 1'b0;
  int            m_rr    = 0;

  always #5 clk = ~clk;

  subunit_ingress_arbiter #(
    .NUM_LINKS    (N),
    .DATA_WIDTH   (DW),
    .HEADER_WIDTH (HW)
  ) dut (
    .clk                       (clk),
    .rst_n                     (rst_n),
    .req_valid                 (req_valid),
    .req_header                (req_header),
    .req_payload               (req_payload),
    .req_payload_valid         (req_payload_valid),
    .grant                     (grant),
    .subunit_input_buffer_full (full),
    .out_header                (out_header),
    .out_header_valid          (out_header_valid),
    .out_payload               (out_payload),
    .out_payload_valid         (out_payload_valid),
    .out_last                  (out_last),
    .busy                      (busy)
  );

  task automatic check(input string name, input logic [HW-1:0] act, input logic [HW-1:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
  endtask

  // ---------------- behavioural model ----------------
  function automatic int pick(input logic [N-1:0] r, input int p);
    for (int k = 0; k < N; k++) begin
      if (r[(p + k) % N]) return (p + k) % N;
    end
    return -1;
  endfunction

  task automatic zero_exp();
    e_grant = '0; e_hdr = '0; e_hdr_v = 1'b0; e_pay = '0;
    e_pay_v = 1'b0; e_last = 1'b0; e_busy = 1'b0; m_rr = 0;
  endtask

  task automatic model_edge(output bit ab);
    @(posedge clk);
    ab = (rst_n !== 1'b1);
    if (ab) zero_exp();
    else begin
      e_hdr_v = 1'b0; e_pay_v = 1'b0; e_last = 1'b0;
    end
  endtask

  // One call = one arbitration attempt followed by the whole packet it starts.
  task automatic model_packet();
    bit ab;
    int w;
    int n;
    logic [HW-1:0] h;
    model_edge(ab); if (ab) return;
    w = pick(req_valid, m_rr);
    if (w < 0) begin e_grant = '0; e_busy = 1'b0; return; end
    e_grant = N'(1) << w;
    e_busy  = 1'b1;
    forever begin
      model_edge(ab); if (ab) return;
      if (!req_valid[w]) begin e_grant = '0; e_busy = 1'b0; return; end
      if (!full) break;
    end
    h = req_header[w*HW +: HW];
    e_hdr = h; e_hdr_v = 1'b1;
    if (h[30]) begin
      n = (h[9:0] == 10'd0) ? 1024 : int'(h[9:0]);
      while (n > 0) begin
        model_edge(ab); if (ab) return;
        if (req_payload_valid[w] && !full) begin
          e_pay = req_payload[w*DW +: DW];
          e_pay_v = 1'b1;
          n--;
          e_last = (n == 0);
        end
      end
    end
    e_grant = '0;
    model_edge(ab); if (ab) return;
    e_busy = 1'b0;
    m_rr = (w + 1) % N;
  endtask

  initial forever model_packet();

  initial forever begin
    @(negedge clk);
    check("grant", grant, e_grant);
    check("out_header_valid", out_header_valid, e_hdr_v);
    check("out_header", out_header, e_hdr);
    check("out_payload_valid", out_payload_valid, e_pay_v);
    check("out_payload", out_payload, e_pay);
    check("out_last", out_last, e_last);
    check("busy", busy, e_busy);
  end

  // ---------------- directed helpers ----------------
  task automatic set_hdr(input int l, input logic [31:0] dw0);
    req_header[l*HW +: HW] = {$urandom, $urandom, $urandom, dw0};
  endtask

  task automatic wait_grant(input string name, output logic [N-1:0] g, output int cyc);
    g = '0;
    cyc = -1;
    for (int i = 0; i < 60; i++) begin
      @(negedge clk);
      if (grant != '0) begin g = grant; cyc = i; return; end
    end
    n_checks++;
    $display("FAIL %s: timeout waiting for grant", name);
  endtask

  task automatic wait_idle(input string name);
    for (int i = 0; i < 20; i++) begin
      if (!busy) begin check({name, " idle"}, busy, 1'b0); return; end
      @(negedge clk);
    end
    check({name, " idle"}, busy, 1'b0);
  endtask

  task automatic run_packet(input string name, input int l, input logic [31:0] dw0,
                            input int nwords, input int hdr_stall, input int pay_stall_idx,
                            input logic [31:0] base, input logic [31:0] step);
    logic [N-1:0] g;
    int cyc;
    int c = 0;
    int got = 0;
    int lasts = 0;
    int stall;
    bit done = 1'b0;
    set_hdr(l, dw0);
    req_payload[l*DW +: DW] = base;
    req_payload_valid[l] = 1'b1;
    req_valid[l] = 1'b1;
    wait_grant(name, g, cyc);
    check({name, " grant"}, g, N'(1) << l);
    check({name, " grant latency"}, cyc, 0);
    stall = hdr_stall;
    full = (stall > 0);
    while (!done && c < nwords + 40) begin
      @(negedge clk);
      c++;
      if (stall > 0) begin stall--; if (stall == 0) full = 1'b0; end
      if (out_header_valid) begin
        req_valid[l] = 1'b0;
        check({name, " hdr dw0"}, out_header[31:0], dw0);
        check({name, " hdr latency"}, c, hdr_stall + 1);
        if (nwords == 0) done = 1'b1;
      end
      if (out_payload_valid) begin
        check({name, " payload"}, out_payload, base + got * step);
        got++;
        check({name, " last"}, out_last, got == nwords);
        if (out_last) lasts++;
        if (got == nwords) done = 1'b1;
        req_payload[l*DW +: DW] = base + got * step;
        if (got == pay_stall_idx) begin full = 1'b1; stall = 2; end
      end
    end
    full = 1'b0;
    req_valid[l] = 1'b0;
    req_payload_valid[l] = 1'b0;
    check({name, " words"}, got, nwords);
    check({name, " lasts"}, lasts, (nwords > 0) ? 1 : 0);
    wait_idle(name);
  endtask

  // ---------------- stimulus ----------------
  initial begin
    logic [N-1:0] g;
    logic [N-1:0] prev;
    logic [N-1:0] fair_exp [5];
    logic [31:0] dw0;
    int cyc;
    int k;
    int seen;

    repeat (3) @(negedge clk);
    check("reset grant", grant, '0);
    check("reset busy", busy, 1'b0);
    check("reset out_header_valid", out_header_valid, 1'b0);
    #1 rst_n = 1'b1;

    run_packet("nodata", 0, 32'h0F000000, 0, 0, -1, 32'h0, 32'h0);
    run_packet("pay2", 2, 32'h6F000002, 2, 0, -1, 32'h40404040, 32'h10101010);
    run_packet("stall", 1, 32'h6F000004, 4, 3, 1, 32'hA0000000, 32'h3);
    run_packet("len0", 3, 32'h6F000000, 1024, 0, -1, 32'h1000, 32'h1);

    // Reset in the middle of a payload from link 1, with link 0 waiting.
    set_hdr(1, 32'h6F000008);
    req_payload[1*DW +: DW] = 32'h11;
    req_payload_valid[1] = 1'b1;
    req_valid[1] = 1'b1;
    wait_grant("rst pkt", g, cyc);
    check("rst pkt grant", g, 4'b0010);
    seen = 0;
    for (int i = 0; i < 40 && seen < 2; i++) begin
      @(negedge clk);
      if (out_payload_valid) begin
        seen++;
        req_payload[1*DW +: DW] = 32'h11 + seen;
      end
    end
    check("rst pkt progress", seen, 2);
    set_hdr(0, 32'h0F000000);
    req_valid[0] = 1'b1;
    #1 rst_n = 1'b0;
    #1;
    check("async rst grant", grant, '0);
    check("async rst hdr_v", out_header_valid, 1'b0);
    check("async rst header", out_header, '0);
    check("async rst pay_v", out_payload_valid, 1'b0);
    check("async rst payload", out_payload, '0);
    check("async rst last", out_last, 1'b0);
    check("async rst busy", busy, 1'b0);
    req_valid[1] = 1'b0;
    req_payload_valid[1] = 1'b0;
    repeat (2) @(negedge clk);
    #1 rst_n = 1'b1;
    wait_grant("post rst", g, cyc);
    check("post rst grant", g, 4'b0001);

    // Continuous requests from every link rotate the grant.
    for (int l = 0; l < N; l++) set_hdr(l, 32'h0F000000 | l);
    req_valid = '1;
    fair_exp[0] = 4'b0001; fair_exp[1] = 4'b0010; fair_exp[2] = 4'b0100;
    fair_exp[3] = 4'b1000; fair_exp[4] = 4'b0001;
    prev = g;
    k = 1;
    for (int i = 0; i < 100 && k < 5; i++) begin
      @(negedge clk);
      if (grant != '0 && prev == '0) begin
        check("fairness grant", grant, fair_exp[k]);
        k++;
      end
      prev = grant;
    end
    check("fairness count", k, 5);
    req_valid = '0;
    wait_idle("fairness");

    // Randomised traffic, back-pressure and withdrawn requests.
    for (int c = 0; c < 2000; c++) begin
      @(negedge clk);
      for (int l = 0; l < N; l++) begin
        if ($urandom_range(0, 3) == 0) req_valid[l] = 1'($urandom_range(0, 1));
        if ($urandom_range(0, 2) == 0) begin
          dw0 = $urandom;
          dw0[9:0] = 10'($urandom_range(1, 5));
          set_hdr(l, dw0);
        end
        req_payload[l*DW +: DW] = $urandom;
        req_payload_valid[l] = ($urandom_range(0, 3) != 0);
      end
      full = ($urandom_range(0, 4) == 0);
    end
    req_valid = '0;
    req_payload_valid = '1;
    full = 1'b0;
    wait_idle("random drain");
    repeat (3) @(negedge clk);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule

// File: doc/subunit_ingress_arbiter.md
SUBUNIT_INGRESS_ARBITER -- requirements
Module: subunit_ingress_arbiter

Interface
REQ-001 Parameter NUM_LINKS, default 4: number of ingress link routers sharing one hardware subunit input.
REQ-002 Parameter DATA_WIDTH, default 32: payload DW width.
REQ-003 Parameter HEADER_WIDTH, default 128: assembled header width, 4 DW, DW0 in bits [31:0].
REQ-004 The block SHALL have one clock and an asynchronous, active-low reset.
REQ-005 clk  in  1  sole clock; all state updates on rising edge.
REQ-006 rst_n  in  1  asynchronous active-low reset.
REQ-007 req_valid  in  NUM_LINKS  router i holds a complete header.
REQ-008 req_header  in  NUM_LINKS*HEADER_WIDTH  router i header, slice i.
REQ-009 req_payload  in  NUM_LINKS*DATA_WIDTH  router i payload DW, slice i.
REQ-010 req_payload_valid  in  NUM_LINKS  router i payload DW valid.
REQ-011 grant  out  NUM_LINKS  one-hot next_ready to routers.
REQ-012 subunit_input_buffer_full  in  1  subunit stall.
REQ-013 out_header / out_header_valid  out  HEADER_WIDTH / 1  forwarded header.
REQ-014 out_payload / out_payload_valid / out_last  out  DATA_WIDTH / 1 / 1  forwarded payload; out_last marks final DW.
REQ-015 busy  out  1  high in any state other than IDLE.

Function
REQ-016 FSM states: IDLE, HDR, PAYLOAD, DONE.
REQ-017 IDLE: if any req_valid, pick winner by round-robin starting at rr_ptr; next cycle enter HDR, grant[winner]=1.
REQ-018 HDR, full=0, req_valid[winner]=1: register out_header=req_header[winner], out_header_valid=1 for exactly one cycle; header flag bit 30 (fmt[1]) =1 -> PAYLOAD, else DONE.
REQ-019 HDR, full=1: hold state, grant held, out_header_valid=0.
REQ-020 HDR, req_valid[winner]=0: return to IDLE; no output; rr_ptr unchanged.
REQ-021 On HDR exit to PAYLOAD, load 11-bit dw_count from header bits [9:0]; value 0 loads 1024.
REQ-022 PAYLOAD: each cycle with req_payload_valid[winner]=1 and full=0, register out_payload=req_payload[winner], out_payload_valid=1, dw_count decrements by 1; otherwise out_payload_valid=0, count held.
REQ-023 out_last=1 with the transfer taken at dw_count==1; next state DONE.
REQ-024 DONE: grant deasserted, rr_ptr=(winner+1) mod NUM_LINKS; next cycle IDLE.
REQ-025 Latency: req_valid sampled in IDLE at edge N -> grant at N+1 -> out_header_valid at N+2 (no stall).
REQ-026 grant SHALL be one-hot or zero; zero in IDLE and DONE; never changes winner mid-packet.
REQ-027 Simultaneous requests: highest priority is rr_ptr, then ascending index with wrap.
REQ-028 Non-winner inputs SHALL be ignored; a router gets no new grant within one cycle of its own DONE.
REQ-029 out_header retains last value when out_header_valid=0; out_payload likewise.

Reset
REQ-030 rst_n low SHALL immediately force state=IDLE, rr_ptr=0, dw_count=0, grant=0, out_header=0, out_header_valid=0, out_payload=0, out_payload_valid=0, out_last=0, busy=0.
REQ-031 Reset mid-packet SHALL abandon the packet; no partial transfer resumes after release.
REQ-032 First arbitration occurs on the first rising edge with rst_n high.

Structure
REQ-033 Shared package ingress_pkg: header width, DW0 fmt bit position (30), length field [9:0], max length 1024, FSM state encoding.
REQ-034 Round-robin pick is sub-module rr_arbiter (req vector + pointer in, one-hot winner + index out, combinational).

Verification
REQ-035 Single 3DW no-data: req_valid[0], header DW0=0x0F000000 -> grant=0001 next cycle, out_header_valid one cycle with same header, DONE, rr_ptr=1.
REQ-036 Payload: link 2 header DW0=0x6F000002, payload 0x40404040, 0x50505050 -> two out_payload_valid, out_last on 0x50505050, then IDLE.
REQ-037 Fairness: req_valid=1111 continuously, no-data headers -> grants 0001,0010,0100,1000,0001 in order.
REQ-038 Stall: full=1 during HDR 3 cycles then during payload DW 2 -> no valids while full, no data lost or duplicated, count correct.
REQ-039 Length 0 (DW0=0x6F000000) -> exactly 1024 payload transfers, out_last on 1024th.
REQ-040 rst_n low during PAYLOAD of link 1 -> all outputs 0 immediately; after release, pending link 0 request granted first.
